// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM steering the shared-memory datapath.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles; outputs decode from the registered state.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low; reset overrides every wait.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q;
  logic   illegal_q;

  // State register plus the registered illegal-opcode pulse, seen during the FETCH after DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYP:      state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_ALUWB;
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Control decode from the current state; only the FETCH write strobes look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dest      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    alu_op        = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'd3;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_ALUWB: begin
        reg_dest  = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dest, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dest      (reg_dest),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .state         (state),
    .illegal_op    (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout:
  // [16] pc_write [15] pc_write_cond [14] i_or_d [13] mem_read [12] mem_write [11] ir_write
  // [10] mem_to_reg [9] reg_dest [8] reg_write [7] alu_src_a [6:5] alu_src_b
  // [4:3] pc_source [2:1] alu_op [0] illegal_op
  localparam logic [16:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_FETCH_ILL  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b1};
  localparam logic [16:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_MEMWR      = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd2,1'b0};
  localparam logic [16:0] C_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,2'd1,1'b0};
  localparam logic [16:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,1'b0};
  localparam logic [16:0] C_ADDIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0};
  localparam logic [16:0] C_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};

  logic [16:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, pc_source,
                alu_op, illegal_op};

  // Compare state and control vector for the current cycle, then advance one clock.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_ctl);
    #1;
    checks++;
    assert (state === exp_state) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, exp_state);
    end
    checks++;
    assert (ctl === exp_ctl) else begin
      errors++;
      $error("FAIL %s ctl: got %b expected %b", tag, ctl, exp_ctl);
    end
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    @(negedge clk);
    @(negedge clk);

    // Reset held: FETCH outputs only, write strobes follow mem_ready.
    mem_ready = 1'b0;
    step("rst_wait", 4'd0, C_FETCH_WAIT);
    mem_ready = 1'b1;
    step("rst_rdy", 4'd0, C_FETCH_RDY);

    // lw, mem_ready=1: 0,1,2,3,4
    reset  = 1'b0;
    opcode = 6'b100011;
    step("lw_f",  4'd0, C_FETCH_RDY);
    step("lw_d",  4'd1, C_DECODE);
    step("lw_a",  4'd2, C_MEMADR);
    step("lw_r",  4'd3, C_MEMRD);
    step("lw_wb", 4'd4, C_MEMWB);

    // sw with three wait cycles in MEMWR
    opcode = 6'b101011;
    step("sw_f", 4'd0, C_FETCH_RDY);
    step("sw_d", 4'd1, C_DECODE);
    step("sw_a", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step("sw_w0", 4'd5, C_MEMWR);
    step("sw_w1", 4'd5, C_MEMWR);
    step("sw_w2", 4'd5, C_MEMWR);
    mem_ready = 1'b1;
    step("sw_w3", 4'd5, C_MEMWR);

    // beq: 0,1,8
    opcode = 6'b000100;
    step("beq_f", 4'd0, C_FETCH_RDY);
    step("beq_d", 4'd1, C_DECODE);
    step("beq_b", 4'd8, C_BRANCH);

    // R-type: 0,1,6,7
    opcode = 6'b000000;
    step("r_f",  4'd0, C_FETCH_RDY);
    step("r_d",  4'd1, C_DECODE);
    step("r_ex", 4'd6, C_EXEC);
    step("r_wb", 4'd7, C_ALUWB);

    // addi: 0,1,10,11
    opcode = 6'b001000;
    step("addi_f",  4'd0, C_FETCH_RDY);
    step("addi_d",  4'd1, C_DECODE);
    step("addi_ex", 4'd10, C_ADDIEX);
    step("addi_wb", 4'd11, C_ADDIWB);

    // j: 0,1,9
    opcode = 6'b000010;
    step("j_f", 4'd0, C_FETCH_RDY);
    step("j_d", 4'd1, C_DECODE);
    step("j_j", 4'd9, C_JUMP);

    // Illegal opcode, then FETCH stalled two cycles: pulse lasts one cycle only.
    opcode = 6'b111111;
    step("ill_f", 4'd0, C_FETCH_RDY);
    step("ill_d", 4'd1, C_DECODE);
    mem_ready = 1'b0;
    step("ill_p",  4'd0, C_FETCH_ILL);
    step("fw_1",   4'd0, C_FETCH_WAIT);
    mem_ready = 1'b1;
    step("fw_rdy", 4'd0, C_FETCH_RDY);

    // lw stalled in MEMRD, reset during the wait: no MEMWB visit.
    opcode = 6'b100011;
    step("lwr_d", 4'd1, C_DECODE);
    step("lwr_a", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step("lwr_r0", 4'd3, C_MEMRD);
    reset = 1'b1;
    step("lwr_r1", 4'd3, C_MEMRD);
    step("lwr_rst", 4'd0, C_FETCH_WAIT);
    mem_ready = 1'b1;
    step("lwr_hold", 4'd0, C_FETCH_RDY);

    // Reset in DECODE with an illegal opcode suppresses illegal_op.
    reset  = 1'b0;
    opcode = 6'b111111;
    step("ri_f", 4'd0, C_FETCH_RDY);
    reset = 1'b1;
    step("ri_d", 4'd1, C_DECODE);
    reset = 1'b0;
    mem_ready = 1'b0;
    step("ri_f2", 4'd0, C_FETCH_WAIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
